// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding, widths and access priority
// for the memory stage and its M/W register.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Access kinds in priority order, highest first after OP_NONE.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_IW   = 3'd1,
        OP_SW   = 3'd2,
        OP_ILW  = 3'd3,
        OP_LW   = 3'd4
    } mem_op_t;

    typedef struct packed {
        logic sel;
        logic we;
        logic load;
    } mem_ctl_t;

    function automatic mem_op_t pick_op(
        input logic wimem,
        input logic wmem,
        input logic ilw,
        input logic lw
    );
        mem_op_t op;
        op = OP_NONE;
        if (wimem)
            op = OP_IW;
        else if (wmem)
            op = OP_SW;
        else if (ilw)
            op = OP_ILW;
        else if (lw)
            op = OP_LW;
        return op;
    endfunction

    function automatic mem_ctl_t op_ctl(input mem_op_t op);
        mem_ctl_t c;
        c = '0;
        unique case (op)
            OP_IW:   c = '{sel: 1'b1, we: 1'b1, load: 1'b0};
            OP_SW:   c = '{sel: 1'b0, we: 1'b1, load: 1'b0};
            OP_ILW:  c = '{sel: 1'b1, we: 1'b0, load: 1'b1};
            OP_LW:   c = '{sel: 1'b0, we: 1'b0, load: 1'b1};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_stage_mw_reg.sv
// mw_reg: M/W pipeline register; every cycle it either commits or
// takes a bubble, while the load-data field only moves when enabled.
module mw_reg
    import mem_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_commit,
    input  logic              i_d_en,
    input  logic [DATA_W-1:0] i_o,
    input  logic [DATA_W-1:0] i_d,
    input  logic              i_wreg,
    input  logic              i_lw,
    input  logic [REG_W-1:0]  i_rd,
    output logic [DATA_W-1:0] o_o,
    output logic [DATA_W-1:0] o_d,
    output logic              o_wreg,
    output logic              o_lw,
    output logic [REG_W-1:0]  o_rd
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_o    <= '0;
            o_wreg <= 1'b0;
            o_lw   <= 1'b0;
            o_rd   <= '0;
        end else if (i_commit) begin
            o_o    <= i_o;
            o_wreg <= i_wreg;
            o_lw   <= i_lw;
            o_rd   <= i_rd;
        end else begin
            o_o    <= '0;
            o_wreg <= 1'b0;
            o_lw   <= 1'b0;
            o_rd   <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            o_d <= '0;
        else if (i_d_en)
            o_d <= i_d;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: issues X/M loads/stores on a shared variable-latency
// memory port, stalls upstream while busy, and owns the M/W register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] oIn,
    input  logic [DATA_W-1:0] dIn,
    input  logic              wMemIn,
    input  logic              wImemIn,
    input  logic              wRegIn,
    input  logic              lwIn,
    input  logic              ilwIn,
    input  logic [REG_W-1:0]  rdIn,
    input  logic [REG_W-1:0]  rsIn,
    output logic              memReq,
    output logic              memSel,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData,
    output logic [DATA_W-1:0] oOut,
    output logic [DATA_W-1:0] dOut,
    output logic              wRegOut,
    output logic              lwOut,
    output logic [REG_W-1:0]  rdOut,
    output logic              stall,
    output logic              timeoutErr
);

    state_t            r_state;
    state_t            w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic              r_terr;

    logic              r_sel;
    logic              r_we;
    logic              r_load;
    logic              r_lw;
    logic              r_wreg;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_o;
    logic [REG_W-1:0]  r_rd;

    mem_op_t           w_op;
    mem_ctl_t          w_ctl;
    logic              w_is_mem;
    logic              w_busy;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd;
    logic [DATA_W-1:0] w_wdata;
    logic              w_tout;

    logic              w_issue;
    logic              w_commit;
    logic              w_d_en;
    logic              w_req;
    logic              w_stall;
    logic              w_set_err;
    logic [DATA_W-1:0] w_c_o;
    logic [DATA_W-1:0] w_c_d;
    logic              w_c_wreg;
    logic              w_c_lw;
    logic [REG_W-1:0]  w_c_rd;

    assign w_op     = pick_op(wImemIn, wMemIn, ilwIn, lwIn);
    assign w_ctl    = op_ctl(w_op);
    assign w_is_mem = (w_op != OP_NONE);
    assign w_busy   = (r_state == BUSY);
    assign w_tout   = (r_cnt == CNT_W'(TIMEOUT));

    // Store data forwarded from the instruction sitting in M/W.
    assign w_fwd_hit = wRegOut && (rdOut != '0) && (rdOut == rsIn);
    assign w_fwd     = lwOut ? dOut : oOut;
    assign w_wdata   = w_fwd_hit ? w_fwd : dIn;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_issue    = 1'b0;
        w_commit   = 1'b0;
        w_d_en     = 1'b0;
        w_req      = 1'b0;
        w_stall    = 1'b0;
        w_set_err  = 1'b0;
        w_c_o      = r_o;
        w_c_d      = '0;
        w_c_wreg   = r_wreg;
        w_c_lw     = r_lw;
        w_c_rd     = r_rd;
        unique case (r_state)
            IDLE: begin
                if (w_is_mem) begin
                    w_req      = 1'b1;
                    w_stall    = 1'b1;
                    w_issue    = 1'b1;
                    w_state_nx = BUSY;
                    w_cnt_nx   = '0;
                end else begin
                    w_commit = 1'b1;
                    w_c_o    = oIn;
                    w_c_wreg = wRegIn;
                    w_c_lw   = 1'b0;
                    w_c_rd   = rdIn;
                end
            end
            BUSY: begin
                if (memAck) begin
                    w_req      = 1'b1;
                    w_commit   = 1'b1;
                    w_d_en     = 1'b1;
                    w_c_d      = r_load ? memRData : '0;
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (w_tout) begin
                    w_commit   = 1'b1;
                    w_d_en     = 1'b1;
                    w_set_err  = 1'b1;
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_req    = 1'b1;
                    w_stall  = 1'b1;
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_set_err)
                r_terr <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_load  <= 1'b0;
            r_lw    <= 1'b0;
            r_wreg  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_o     <= '0;
            r_rd    <= '0;
        end else if (w_issue) begin
            r_sel   <= w_ctl.sel;
            r_we    <= w_ctl.we;
            r_load  <= w_ctl.load;
            r_lw    <= lwIn | ilwIn;
            r_wreg  <= wRegIn;
            r_addr  <= oIn[ADDR_W-1:0];
            r_wdata <= w_wdata;
            r_o     <= oIn;
            r_rd    <= rdIn;
        end
    end

    mw_reg u_mw_reg (
        .clock    (clock),
        .reset    (reset),
        .i_commit (w_commit),
        .i_d_en   (w_d_en),
        .i_o      (w_c_o),
        .i_d      (w_c_d),
        .i_wreg   (w_c_wreg),
        .i_lw     (w_c_lw),
        .i_rd     (w_c_rd),
        .o_o      (oOut),
        .o_d      (dOut),
        .o_wreg   (wRegOut),
        .o_lw     (lwOut),
        .o_rd     (rdOut)
    );

    // Reset masks the combinational request so it drops mid-cycle.
    assign memReq     = w_req & ~reset;
    assign stall      = w_stall & ~reset;
    assign memSel     = memReq & (w_busy ? r_sel : w_ctl.sel);
    assign memWe      = memReq & (w_busy ? r_we : w_ctl.we);
    assign memAddr    = memReq ? (w_busy ? r_addr : oIn[ADDR_W-1:0]) : '0;
    assign memWData   = memReq ? (w_busy ? r_wdata : w_wdata) : '0;
    assign timeoutErr = r_terr;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random instruction stream against a
// transaction-level model of the M/W register and memory handshake.
module tb_mem_stage;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 15;

    logic              clock;
    logic              reset;
    logic [31:0]       oIn;
    logic [31:0]       dIn;
    logic              wMemIn;
    logic              wImemIn;
    logic              wRegIn;
    logic              lwIn;
    logic              ilwIn;
    logic [4:0]        rdIn;
    logic [4:0]        rsIn;
    logic              memReq;
    logic              memSel;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWData;
    logic              memAck;
    logic [31:0]       memRData;
    logic [31:0]       oOut;
    logic [31:0]       dOut;
    logic              wRegOut;
    logic              lwOut;
    logic [4:0]        rdOut;
    logic              stall;
    logic              timeoutErr;

    int checks;
    int errors;

    logic [31:0] m_o;
    logic [31:0] m_d;
    logic        m_wreg;
    logic        m_lw;
    logic [4:0]  m_rd;
    logic        m_terr;

    mem_stage #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .oIn        (oIn),
        .dIn        (dIn),
        .wMemIn     (wMemIn),
        .wImemIn    (wImemIn),
        .wRegIn     (wRegIn),
        .lwIn       (lwIn),
        .ilwIn      (ilwIn),
        .rdIn       (rdIn),
        .rsIn       (rsIn),
        .memReq     (memReq),
        .memSel     (memSel),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memAck     (memAck),
        .memRData   (memRData),
        .oOut       (oOut),
        .dOut       (dOut),
        .wRegOut    (wRegOut),
        .lwOut      (lwOut),
        .rdOut      (rdOut),
        .stall      (stall),
        .timeoutErr (timeoutErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mw(input string tag);
        chk({tag, ".oOut"}, oOut, m_o);
        chk({tag, ".dOut"}, dOut, m_d);
        chk({tag, ".wRegOut"}, 32'(wRegOut), 32'(m_wreg));
        chk({tag, ".lwOut"}, 32'(lwOut), 32'(m_lw));
        chk({tag, ".rdOut"}, 32'(rdOut), 32'(m_rd));
        chk({tag, ".timeoutErr"}, 32'(timeoutErr), 32'(m_terr));
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".oOut"}, oOut, 32'h0);
        chk({tag, ".dOut"}, dOut, m_d);
        chk({tag, ".wRegOut"}, 32'(wRegOut), 32'h0);
        chk({tag, ".lwOut"}, 32'(lwOut), 32'h0);
        chk({tag, ".rdOut"}, 32'(rdOut), 32'h0);
        chk({tag, ".timeoutErr"}, 32'(timeoutErr), 32'(m_terr));
    endtask

    task automatic drive_nop();
        oIn = '0; dIn = '0; wMemIn = 0; wImemIn = 0; wRegIn = 0;
        lwIn = 0; ilwIn = 0; rdIn = '0; rsIn = '0;
    endtask

    // lat = BUSY cycle carrying the ack; 0 means the memory never answers.
    task automatic run_op(
        input string tag,
        input logic wimem, input logic wmem,
        input logic ilw, input logic lw, input logic wreg,
        input logic [4:0] rd, input logic [4:0] rs,
        input logic [31:0] o, input logic [31:0] d,
        input int lat, input logic [31:0] rdata
    );
        logic        mem;
        logic        esel;
        logic        ewe;
        logic        eload;
        logic [31:0] ewd;
        logic [11:0] eaddr;
        int          limit;
        mem   = wimem | wmem | ilw | lw;
        esel  = wimem | (!wmem & ilw);
        ewe   = wimem | wmem;
        eload = !ewe & (ilw | lw);
        eaddr = o[11:0];
        if (m_wreg && m_rd != 0 && m_rd == rs)
            ewd = m_lw ? m_d : m_o;
        else
            ewd = d;
        wImemIn = wimem; wMemIn = wmem; ilwIn = ilw; lwIn = lw;
        wRegIn = wreg; rdIn = rd; rsIn = rs; oIn = o; dIn = d;
        memAck = 1'($urandom_range(0, 1));
        memRData = $urandom;
        @(negedge clock);
        chk({tag, ".issue.stall"}, 32'(stall), 32'(mem));
        chk({tag, ".issue.memReq"}, 32'(memReq), 32'(mem));
        if (mem) begin
            chk({tag, ".issue.memSel"}, 32'(memSel), 32'(esel));
            chk({tag, ".issue.memWe"}, 32'(memWe), 32'(ewe));
            chk({tag, ".issue.memAddr"}, 32'(memAddr), 32'(eaddr));
            chk({tag, ".issue.memWData"}, memWData, ewd);
        end
        @(posedge clock); #1;
        if (!mem) begin
            m_o = o; m_wreg = wreg; m_lw = 1'b0; m_rd = rd;
            chk_mw({tag, ".commit"});
            return;
        end
        chk_bubble({tag, ".issue.mw"});
        limit = (lat == 0) ? TIMEOUT + 1 : lat;
        for (int k = 1; k <= limit; k++) begin
            memAck = (k == lat);
            memRData = (k == lat) ? rdata : $urandom;
            @(negedge clock);
            chk({tag, ".busy.stall"}, 32'(stall), 32'(k != limit));
            if (k != limit || k == lat) begin
                chk({tag, ".busy.memReq"}, 32'(memReq), 32'h1);
                chk({tag, ".busy.memSel"}, 32'(memSel), 32'(esel));
                chk({tag, ".busy.memWe"}, 32'(memWe), 32'(ewe));
                chk({tag, ".busy.memAddr"}, 32'(memAddr), 32'(eaddr));
                chk({tag, ".busy.memWData"}, memWData, ewd);
            end
            @(posedge clock); #1;
            if (k != limit)
                chk_bubble({tag, ".busy.mw"});
        end
        memAck = 1'b0;
        m_o = o; m_wreg = wreg; m_lw = ilw | lw; m_rd = rd;
        m_d = (lat != 0 && eload) ? rdata : 32'h0;
        if (lat == 0)
            m_terr = 1'b1;
        chk_mw({tag, ".commit"});
    endtask

    initial begin
        logic [2:0]  kind;
        int          lat;
        checks = 0;
        errors = 0;
        m_o = '0; m_d = '0; m_wreg = 0; m_lw = 0; m_rd = '0; m_terr = 0;
        reset = 1'b1;
        memAck = 1'b0;
        memRData = '0;
        drive_nop();
        #12;
        chk("reset.memReq", 32'(memReq), 32'h0);
        chk("reset.stall", 32'(stall), 32'h0);
        chk("reset.memAddr", 32'(memAddr), 32'h0);
        chk_mw("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        run_op("alu", 0, 0, 0, 0, 1, 5'd3, 5'd0, 32'h10, 32'h0, 0, 32'h0);
        chk("alu.oOut", oOut, 32'h10);
        run_op("lw", 0, 0, 0, 1, 1, 5'd7, 5'd0, 32'h40, 32'h0,
               3, 32'hDEADBEEF);
        chk("lw.dOut", dOut, 32'hDEADBEEF);
        run_op("alu5", 0, 0, 0, 0, 1, 5'd5, 5'd0, 32'h77, 32'h0, 0, 32'h0);
        run_op("sw_fwd", 0, 1, 0, 0, 0, 5'd0, 5'd5, 32'h84, 32'h1234,
               2, 32'h0);
        run_op("iw", 1, 0, 0, 0, 0, 5'd0, 5'd0, 32'h100, 32'hCAFE,
               1, 32'h0);
        run_op("ilw", 0, 0, 1, 0, 1, 5'd9, 5'd0, 32'h104, 32'h0,
               2, 32'h55AA55AA);
        run_op("lw_fwd", 0, 0, 0, 1, 1, 5'd2, 5'd9, 32'h108, 32'h1,
               1, 32'h0BAD0BAD);
        run_op("tmo", 0, 0, 0, 1, 1, 5'd4, 5'd0, 32'h200, 32'h0, 0, 32'h0);
        chk("tmo.timeoutErr", 32'(timeoutErr), 32'h1);
        chk("tmo.dOut", dOut, 32'h0);
        run_op("after_tmo", 0, 0, 0, 0, 1, 5'd6, 5'd0, 32'h33, 32'h0,
               0, 32'h0);

        for (int n = 0; n < 150; n++) begin
            kind = 3'($urandom_range(0, 5));
            lat = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 6);
            run_op("rnd", kind == 2, kind == 3, kind == 4, kind == 5,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), $urandom, $urandom,
                   lat, $urandom);
        end

        wImemIn = 0; wMemIn = 0; ilwIn = 0; lwIn = 1; wRegIn = 1;
        rdIn = 5'd8; rsIn = 5'd0; oIn = 32'h300; dIn = 32'h0;
        memAck = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_busy.memReq", 32'(memReq), 32'h0);
        chk("rst_busy.stall", 32'(stall), 32'h0);
        chk("rst_busy.memSel", 32'(memSel), 32'h0);
        chk("rst_busy.memWe", 32'(memWe), 32'h0);
        chk("rst_busy.memAddr", 32'(memAddr), 32'h0);
        chk("rst_busy.memWData", memWData, 32'h0);
        m_o = '0; m_d = '0; m_wreg = 0; m_lw = 0; m_rd = '0; m_terr = 0;
        chk_mw("rst_busy");
        @(posedge clock); #1;
        reset = 1'b0;
        drive_nop();
        memAck = 1'b1;
        memRData = 32'hFFFF0000;
        @(negedge clock);
        chk("stale_ack.memReq", 32'(memReq), 32'h0);
        chk("stale_ack.stall", 32'(stall), 32'h0);
        @(posedge clock); #1;
        memAck = 1'b0;
        chk_mw("stale_ack");
        run_op("post_rst", 0, 0, 0, 0, 1, 5'd1, 5'd0, 32'h99, 32'h0,
               0, 32'h0);
        run_op("post_rst_lw", 0, 0, 0, 1, 1, 5'd1, 5'd0, 32'h44, 32'h0,
               2, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
